// File: rtl/mem_data_lsu.sv
`timescale 1ns/1ps
// mem_data_lsu: load/store unit in front of the data array.
// Accepts one load or store per cycle through a valid/ready request channel
// and returns the result through a one-entry registered response buffer.
// Handles RISC-V access sizing (B/H/W/D, signed/unsigned), byte-lane writes
// and fault detection (illegal funct3, misaligned, out-of-range).
//
// Build option: MEM_DATA_LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned accesses fault with cause 1 (no write, rdata 0)
//   undefined -> misaligned accesses are silently aligned down to the size
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       request present
//   req_ready       request can be taken this cycle (combinational)
//   req_we          1 = store, 0 = load
//   req_funct3      RISC-V funct3 size/sign code
//   req_addr        byte address
//   req_wdata       store data, right-aligned
//   resp_valid      response held in the output buffer
//   resp_ready      consumer takes the response
//   resp_rdata      extended load data; 0 for stores and faults
//   resp_fault      access faulted
//   resp_cause      0 none, 1 misaligned, 2 out-of-range, 3 illegal funct3
//
// The array is never reset; its contents survive rst_n.
module mem_data_lsu #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDRESSLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDRESSLEN-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_fault,
    output logic [1:0]            resp_cause
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned WIDXW = ADDRESSLEN - OFFS;
    localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned XW    = $clog2(XLEN);

    localparam logic [WIDXW-1:0] DEPTH_W = WIDXW'(DEPTH);

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
`ifdef MEM_DATA_LSU_MISALIGN_TRAP_EN
    localparam logic [1:0] CAUSE_MISAL  = 2'd1;
`endif
    localparam logic [1:0] CAUSE_RANGE  = 2'd2;
    localparam logic [1:0] CAUSE_FUNCT3 = 2'd3;

    // Data array: no reset, written lane-by-lane on the accept edge.
    logic [XLEN-1:0] mem_q [DEPTH];

    // Response buffer registers.
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_fault_q, resp_fault_d;
    logic [1:0]      resp_cause_q, resp_cause_d;

    logic            accept;
    logic [1:0]      size_log2;
    logic            is_unsigned;
    logic            f3_legal;
    logic [OFFS-1:0] byte_off;
    logic [OFFS-1:0] low_mask;
    logic [OFFS-1:0] eff_off;
    logic [WIDXW-1:0] word_idx_full;
    logic [IDXW-1:0] mem_idx;
    logic            in_range;
    logic [1:0]      cause;
    logic            fault;
    logic [BYTES-1:0] size_lanes;
    logic [BYTES-1:0] lane_mask;
    logic [XLEN-1:0] wdata_sh;
    logic            wr_en;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] keep_mask;
    logic [XW-1:0]   msb_idx;
    logic            sign_bit;
    logic [XLEN-1:0] load_data;

    // Buffer can take a new response when empty or being drained this cycle.
    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;

    // funct3 decode: access size, signedness, legality for this XLEN.
    always_comb begin
        size_log2   = 2'd0;
        is_unsigned = 1'b0;
        f3_legal    = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'd0: begin size_log2 = 2'd0; f3_legal = 1'b1; end
                3'd1: begin size_log2 = 2'd1; f3_legal = 1'b1; end
                3'd2: begin size_log2 = 2'd2; f3_legal = 1'b1; end
                3'd3: begin size_log2 = 2'd3; f3_legal = (XLEN == 64); end
                default: f3_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'd0: begin size_log2 = 2'd0; f3_legal = 1'b1; end
                3'd1: begin size_log2 = 2'd1; f3_legal = 1'b1; end
                3'd2: begin size_log2 = 2'd2; f3_legal = 1'b1; end
                3'd3: begin size_log2 = 2'd3; f3_legal = (XLEN == 64); end
                3'd4: begin size_log2 = 2'd0; is_unsigned = 1'b1; f3_legal = 1'b1; end
                3'd5: begin size_log2 = 2'd1; is_unsigned = 1'b1; f3_legal = 1'b1; end
                3'd6: begin size_log2 = 2'd2; is_unsigned = 1'b1; f3_legal = (XLEN == 64); end
                default: f3_legal = 1'b0;
            endcase
        end
    end

    // Address split and alignment handling.
    assign byte_off      = req_addr[OFFS-1:0];
    assign word_idx_full = req_addr[ADDRESSLEN-1:OFFS];
    assign mem_idx       = word_idx_full[IDXW-1:0];
    assign in_range      = word_idx_full < DEPTH_W;
    assign low_mask      = OFFS'((32'd1 << size_log2) - 32'd1);

`ifdef MEM_DATA_LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(byte_off & low_mask);
    assign eff_off    = byte_off;
`else
    // Offset bits below the access size are dropped: access aligns down.
    assign eff_off    = byte_off & ~low_mask;
`endif

    // Fault priority: illegal funct3, then misaligned, then out-of-range.
    always_comb begin
        cause = CAUSE_NONE;
        if (!f3_legal) begin
            cause = CAUSE_FUNCT3;
        end
`ifdef MEM_DATA_LSU_MISALIGN_TRAP_EN
        else if (misaligned) begin
            cause = CAUSE_MISAL;
        end
`endif
        else if (!in_range) begin
            cause = CAUSE_RANGE;
        end
    end
    assign fault = (cause != CAUSE_NONE);

    // Store lane selection and data placement.
    assign size_lanes = BYTES'((32'd1 << (32'd1 << size_log2)) - 32'd1);
    assign lane_mask  = size_lanes << eff_off;
    assign wdata_sh   = req_wdata << {eff_off, 3'b000};
    assign wr_en      = accept && req_we && !fault;

    // Array write; only the selected byte lanes change.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lane_mask[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // Load path: shift addressed bytes down, then sign/zero-extend.
    assign rd_word  = mem_q[mem_idx];
    assign rd_shift = rd_word >> {eff_off, 3'b000};
    assign msb_idx  = XW'((32'd8 << size_log2) - 32'd1);
    assign sign_bit = rd_shift[msb_idx];

    always_comb begin
        keep_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            keep_mask[b*8 +: 8] = {8{size_lanes[b]}};
        end
    end

    assign load_data = (rd_shift & keep_mask) |
                       ((!is_unsigned && sign_bit) ? ~keep_mask : '0);

    // Response buffer next state: capture on accept, clear when drained.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        resp_cause_d = resp_cause_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = (req_we || fault) ? '0 : load_data;
            resp_fault_d = fault;
            resp_cause_d = cause;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            resp_cause_q <= resp_cause_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign resp_cause = resp_cause_q;

endmodule

// File: tb/tb_mem_data_lsu.sv
`timescale 1ns/1ps
// Bench for mem_data_lsu: byte-level reference model, scoreboard queue,
// directed cases followed by randomized traffic with random backpressure.
module tb_mem_data_lsu;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned ADDRESSLEN = 32;
    localparam int unsigned BYTES      = XLEN / 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [2:0]            req_funct3 = 3'd0;
    logic [ADDRESSLEN-1:0] req_addr = '0;
    logic [XLEN-1:0]       req_wdata = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_fault;
    logic [1:0]            resp_cause;

    mem_data_lsu #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDRESSLEN(ADDRESSLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .resp_cause(resp_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            fault;
        logic [1:0]      cause;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mem_b [DEPTH*BYTES];
    int         errors = 0;
    int         checks = 0;
    bit         rand_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat byte array, accesses assembled byte by byte.
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [XLEN-1:0] wdata);
        exp_t            e;
        int              nb;
        bit              uns;
        bit              legal;
        bit              misal;
        int              off;
        longint unsigned widx;
        int              base;
        logic [XLEN-1:0] v;
        e.rdata = '0;
        e.fault = 1'b0;
        e.cause = 2'd0;
        nb = 1; uns = 1'b0; legal = 1'b1;
        case (f3)
            3'd0: nb = 1;
            3'd1: nb = 2;
            3'd2: nb = 4;
            3'd4: begin nb = 1; uns = 1'b1; end
            3'd5: begin nb = 2; uns = 1'b1; end
            default: legal = 1'b0;
        endcase
        if (we && f3 > 3'd2) legal = 1'b0;
        off   = int'(addr % BYTES);
        widx  = longint'(addr / BYTES);
        misal = (off % nb) != 0;
`ifndef MEM_DATA_LSU_MISALIGN_TRAP_EN
        if (misal) begin
            off   = off - (off % nb);
            misal = 1'b0;
        end
`endif
        if (!legal)              e.cause = 2'd3;
        else if (misal)          e.cause = 2'd1;
        else if (widx >= DEPTH)  e.cause = 2'd2;
        if (e.cause != 2'd0) begin
            e.fault = 1'b1;
            return e;
        end
        base = int'(widx) * BYTES + off;
        if (we) begin
            for (int i = 0; i < nb; i++) mem_b[base+i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[base+i];
            if (!uns && v[8*nb-1]) begin
                for (int i = nb; i < BYTES; i++) v[8*i +: 8] = 8'hFF;
            end
            e.rdata = v;
        end
        return e;
    endfunction

    // Drive one request starting at a negedge; returns at the negedge after accept.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [XLEN-1:0] wd, output int waits);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        waits = 0;
        for (int t = 0; t < 200; t++) begin
            if (rand_bp) resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (req_ready) begin
                sb_q.push_back(model(we, f3, addr, wd));
                @(negedge clk);
                req_valid = 1'b0;
                return;
            end
            waits++;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: req_ready stuck at 0 for addr 0x%0h", addr);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_bp) resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
    endtask

    // Monitor: compares every consumed response with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata 0x%0h with empty scoreboard", resp_rdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                    chk("resp_fault", 64'(resp_fault), 64'(e.fault));
                    chk("resp_cause", 64'(resp_cause), 64'(e.cause));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int              w;
        logic [2:0]      f3;
        logic [31:0]     a;
        logic [2:0]      legal_f3 [8];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4;
        legal_f3[4] = 3'd5; legal_f3[5] = 3'd2; legal_f3[6] = 3'd0; legal_f3[7] = 3'd1;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_resp_fault", 64'(resp_fault), 64'd0);
        chk("rst_resp_cause", 64'(resp_cause), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload every word through the store path
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 3'd2, 32'(i * BYTES), $urandom, w);
        idle(3);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Store then load back-to-back
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, w);
        issue(1'b0, 3'd2, 32'h10, '0, w);
        #1;
        chk("load_latency_valid", 64'(resp_valid), 64'd1);
        @(negedge clk);

        // Byte store and sized loads
        issue(1'b1, 3'd0, 32'h11, 32'h7F, w);
        issue(1'b0, 3'd0, 32'h11, '0, w);
        issue(1'b0, 3'd4, 32'h13, '0, w);
        issue(1'b0, 3'd1, 32'h12, '0, w);
        issue(1'b0, 3'd5, 32'h12, '0, w);
        issue(1'b0, 3'd2, 32'h10, '0, w);

        // Faults
        issue(1'b0, 3'd2, 32'(DEPTH * BYTES), '0, w);
        issue(1'b1, 3'd2, 32'(DEPTH * BYTES), 32'hFFFFFFFF, w);
        issue(1'b0, 3'd2, 32'h0, '0, w);
        issue(1'b0, 3'd7, 32'h20, '0, w);
        issue(1'b1, 3'd7, 32'h20, 32'h12345678, w);
        issue(1'b0, 3'd3, 32'h20, '0, w);
        issue(1'b0, 3'd6, 32'h20, '0, w);
        issue(1'b1, 3'd4, 32'h20, 32'h12345678, w);
        issue(1'b0, 3'd2, 32'h20, '0, w);
        issue(1'b0, 3'd7, 32'(DEPTH * BYTES + 1), '0, w);
        issue(1'b0, 3'd2, 32'(DEPTH * BYTES + 1), '0, w);

        // Misaligned accesses
        issue(1'b0, 3'd2, 32'h6, '0, w);
        issue(1'b0, 3'd1, 32'h3, '0, w);
        issue(1'b1, 3'd2, 32'h5, 32'hCAFEF00D, w);
        issue(1'b0, 3'd2, 32'h4, '0, w);
        issue(1'b1, 3'd1, 32'h9, 32'h0000A55A, w);
        issue(1'b0, 3'd2, 32'h8, '0, w);

        // Backpressure: response held, request stalled for 3 cycles
        idle(3);
        resp_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h10, '0, w);
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h14; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_resp_valid", 64'(resp_valid), 64'd1);
            chk("bp_resp_rdata", 64'(resp_rdata), 64'(sb_q[0].rdata));
            chk("bp_resp_cause", 64'(resp_cause), 64'(sb_q[0].cause));
            @(negedge clk);
        end
        resp_ready = 1'b1;
        issue(1'b0, 3'd2, 32'h14, '0, w);
        chk("bp_accept_waits", 64'(w), 64'd0);
        idle(3);

        // Asynchronous reset with a response pending
        resp_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h18, '0, w);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_resp_valid", 64'(resp_valid), 64'd0);
        chk("arst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("arst_resp_fault", 64'(resp_fault), 64'd0);
        chk("arst_resp_cause", 64'(resp_cause), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        issue(1'b0, 3'd2, 32'h10, '0, w);
        idle(2);

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 600; n++) begin
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) < 9) ? 32'($urandom_range(0, DEPTH * BYTES - 1))
                                            : 32'($urandom_range(DEPTH * BYTES, DEPTH * BYTES + 64));
            issue(1'($urandom_range(0, 1)), f3, a, $urandom, w);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        rand_bp = 1'b0;
        resp_ready = 1'b1;

        // Drain
        for (int t = 0; t < 50 && (sb_q.size() != 0 || resp_valid); t++) @(negedge clk);
        #3;
        chk("drain_scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
